ahb_arbiter: RTL and testbench

AHB_ARBITER -- requirements
Module: ahb_arbiter

---
 rtl/ahb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ahb_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter.sv
// Three-master AHB bus arbiter: round-robin grant with M0 as default master,
// grant held across fixed-length bursts and locked sequences.
module ahb_arbiter (
   input  logic       HCLK,
   input  logic       HRESETn,
   input  logic [2:0] HBUSREQ,
   input  logic [2:0] HLOCK,
   input  logic [1:0] HTRANS,
   input  logic [2:0] HBURST,
   input  logic       HREADY,
   input  logic [1:0] HRESP,
   output logic [2:0] HGRANT,
   output logic [3:0] HMASTER,
   output logic       HMASTLOCK
);

   localparam int unsigned NUM_M  = 3;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned MST_W  = 4;

   localparam logic [1:0] ST_ARB    = 2'b00;
   localparam logic [1:0] ST_BURST  = 2'b01;
   localparam logic [1:0] ST_LOCKED = 2'b10;

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;
   localparam logic [1:0] RESP_ERR  = 2'd1;

   logic [1:0]       r_state,    w_state_nxt;
   logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
   logic [1:0]       r_ptr,      w_ptr_nxt;
   logic [NUM_M-1:0] r_grant,    w_grant_nxt;
   logic [MST_W-1:0] r_master,   w_master_nxt;
   logic             r_mastlock, w_mastlock_nxt;

   logic [1:0]       w_gidx;
   logic             w_lock_g;
   logic             w_burst_start;
   logic [CNT_W-1:0] w_burst_len;
   logic [CNT_W-1:0] w_cnt_adv;
   logic             w_ap;
   logic             w_rr_found;
   logic [1:0]       w_rr_idx;
   logic [1:0]       w_cand;

   // Decode of the current grant, burst length and arbitration point
   always_comb begin
      case (r_grant)
         3'b010:  w_gidx = 2'd1;
         3'b100:  w_gidx = 2'd2;
         default: w_gidx = 2'd0;
      endcase
      w_lock_g      = |(HLOCK & r_grant);
      w_burst_start = (HTRANS == TR_NONSEQ) && (HBURST >= 3'd2);
      case (HBURST[2:1])
         2'b01:   w_burst_len = CNT_W'(3);
         2'b10:   w_burst_len = CNT_W'(7);
         2'b11:   w_burst_len = CNT_W'(15);
         default: w_burst_len = '0;
      endcase
      if (w_burst_start)
         w_cnt_adv = w_burst_len;
      else if ((HTRANS == TR_SEQ) && (r_cnt != '0))
         w_cnt_adv = r_cnt - CNT_W'(1);
      else
         w_cnt_adv = r_cnt;
      w_ap = HREADY && !w_lock_g &&
             (((r_state == ST_ARB) && !w_burst_start) ||
              ((r_state == ST_BURST) && (r_cnt == CNT_W'(1)) && (HTRANS == TR_SEQ)));
   end

   // Round-robin scan starting after the last granted master; nearest wins
   always_comb begin
      w_rr_found = 1'b0;
      w_rr_idx   = 2'd0;
      w_cand     = 2'd0;
      for (int k = NUM_M; k >= 1; k--) begin
         w_cand = 2'((32'(r_ptr) + 32'(k)) % NUM_M);
         if (HBUSREQ[w_cand]) begin
            w_rr_found = 1'b1;
            w_rr_idx   = w_cand;
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_ptr_nxt      = r_ptr;
      w_grant_nxt    = r_grant;
      w_master_nxt   = r_master;
      w_mastlock_nxt = r_mastlock;
      if (HREADY) begin
         w_master_nxt   = MST_W'(w_gidx);
         w_mastlock_nxt = w_lock_g;
         case (r_state)
            ST_ARB: begin
               if (w_lock_g) begin
                  w_state_nxt = ST_LOCKED;
                  w_cnt_nxt   = w_burst_start ? w_burst_len : '0;
               end else if (w_burst_start) begin
                  w_state_nxt = ST_BURST;
                  w_cnt_nxt   = w_burst_len;
               end
            end
            ST_BURST: begin
               if (w_lock_g) begin
                  w_state_nxt = ST_LOCKED;
                  w_cnt_nxt   = w_cnt_adv;
               end else if ((HRESP == RESP_ERR) || (HTRANS == TR_IDLE)) begin
                  w_state_nxt = ST_ARB;
                  w_cnt_nxt   = '0;
               end else if (HTRANS == TR_NONSEQ) begin
                  // Early termination: a new fixed burst restarts the count
                  if (w_burst_start) begin
                     w_cnt_nxt = w_burst_len;
                  end else begin
                     w_state_nxt = ST_ARB;
                     w_cnt_nxt   = '0;
                  end
               end else if (HTRANS == TR_SEQ) begin
                  if (r_cnt <= CNT_W'(1)) begin
                     w_state_nxt = ST_ARB;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = r_cnt - CNT_W'(1);
                  end
               end
            end
            ST_LOCKED: begin
               // Lock owns the exit; error responses do not release it
               if (!w_lock_g) begin
                  w_state_nxt = ST_ARB;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = w_cnt_adv;
               end
            end
            default: begin
               w_state_nxt = ST_ARB;
               w_cnt_nxt   = '0;
            end
         endcase
         if (w_ap) begin
            if (w_rr_found) begin
               w_grant_nxt = NUM_M'(3'b001 << w_rr_idx);
               w_ptr_nxt   = w_rr_idx;
            end else begin
               w_grant_nxt = NUM_M'(3'b001);
            end
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state    <= ST_ARB;
         r_cnt      <= '0;
         r_ptr      <= 2'd0;
         r_grant    <= NUM_M'(3'b001);
         r_master   <= '0;
         r_mastlock <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ptr      <= w_ptr_nxt;
         r_grant    <= w_grant_nxt;
         r_master   <= w_master_nxt;
         r_mastlock <= w_mastlock_nxt;
      end
   end

   assign HGRANT    = r_grant;
   assign HMASTER   = r_master;
   assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scenario bench for ahb_arbiter: expected grant/master/lock pushed per driven
// cycle and popped after the clock edge that produces them.
module tb_ahb_arbiter;

   localparam logic [1:0] IDL = 2'd0;
   localparam logic [1:0] BSY = 2'd1;
   localparam logic [1:0] NSQ = 2'd2;
   localparam logic [1:0] SEQ = 2'd3;
   localparam logic [2:0] SGL   = 3'd0;
   localparam logic [2:0] INC   = 3'd1;
   localparam logic [2:0] INC4  = 3'd3;
   localparam logic [2:0] INC8  = 3'd5;
   localparam logic [2:0] WR16  = 3'd6;
   localparam logic [2:0] INC16 = 3'd7;

   typedef struct packed {
      logic [2:0] g;
      logic [3:0] m;
      logic       l;
   } exp_t;

   typedef struct packed {
      logic [2:0] req;
      logic [2:0] lock;
      logic [1:0] tr;
      logic [2:0] bu;
      logic       rdy;
      logic       er;
      exp_t       e;
   } row_t;

   logic       HCLK;
   logic       HRESETn;
   logic [2:0] HBUSREQ;
   logic [2:0] HLOCK;
   logic [1:0] HTRANS;
   logic [2:0] HBURST;
   logic       HREADY;
   logic [1:0] HRESP;
   logic [2:0] HGRANT;
   logic [3:0] HMASTER;
   logic       HMASTLOCK;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   ahb_arbiter dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HBUSREQ   (HBUSREQ),
      .HLOCK     (HLOCK),
      .HTRANS    (HTRANS),
      .HBURST    (HBURST),
      .HREADY    (HREADY),
      .HRESP     (HRESP),
      .HGRANT    (HGRANT),
      .HMASTER   (HMASTER),
      .HMASTLOCK (HMASTLOCK)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   function automatic row_t mk(input logic [2:0] req, input logic [2:0] lock,
                               input logic [1:0] tr, input logic [2:0] bu,
                               input logic rdy, input logic er,
                               input logic [2:0] g, input logic [3:0] m, input logic l);
      row_t r;
      r.req  = req;
      r.lock = lock;
      r.tr   = tr;
      r.bu   = bu;
      r.rdy  = rdy;
      r.er   = er;
      r.e    = {g, m, l};
      return r;
   endfunction

   // Drive one bus cycle, record its expected outcome, step past the edge
   task automatic apply(input row_t r);
      HBUSREQ = r.req;
      HLOCK   = r.lock;
      HTRANS  = r.tr;
      HBURST  = r.bu;
      HREADY  = r.rdy;
      HRESP   = {1'b0, r.er};
      exp_q.push_back(r.e);
      @(posedge HCLK);
      #1;
   endtask

   task automatic test_reset();
      exp_t got, e;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back({3'b001, 4'd0, 1'b0});
         @(posedge HCLK);
         #1;
         got = {HGRANT, HMASTER, HMASTLOCK};
         e   = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset[%0d]: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                     i, got.g, got.m, got.l, e.g, e.m, e.l);
         end
      end
      HRESETn = 1'b1;
   endtask

   task automatic test_round_robin();
      row_t rows[$];
      exp_t got, e;
      rows.push_back(mk(3'b111, 3'b000, NSQ, SGL, 1'b1, 1'b0, 3'b010, 4'd0, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, NSQ, SGL, 1'b1, 1'b0, 3'b100, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, NSQ, SGL, 1'b1, 1'b0, 3'b001, 4'd2, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, NSQ, SGL, 1'b1, 1'b0, 3'b010, 4'd0, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, NSQ, SGL, 1'b0, 1'b0, 3'b010, 4'd0, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, NSQ, SGL, 1'b1, 1'b0, 3'b100, 4'd1, 1'b0));
      foreach (rows[i]) begin
         apply(rows[i]);
         got = {HGRANT, HMASTER, HMASTLOCK};
         e   = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL round_robin[%0d]: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                     i, got.g, got.m, got.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_default_grant();
      row_t rows[$];
      exp_t got, e;
      rows.push_back(mk(3'b000, 3'b000, IDL, SGL, 1'b1, 1'b0, 3'b001, 4'd2, 1'b0));
      rows.push_back(mk(3'b000, 3'b000, IDL, SGL, 1'b1, 1'b0, 3'b001, 4'd0, 1'b0));
      rows.push_back(mk(3'b011, 3'b000, IDL, SGL, 1'b1, 1'b0, 3'b001, 4'd0, 1'b0));
      rows.push_back(mk(3'b011, 3'b000, IDL, SGL, 1'b1, 1'b0, 3'b010, 4'd0, 1'b0));
      rows.push_back(mk(3'b010, 3'b000, IDL, SGL, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      foreach (rows[i]) begin
         apply(rows[i]);
         got = {HGRANT, HMASTER, HMASTLOCK};
         e   = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL default_grant[%0d]: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                     i, got.g, got.m, got.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_burst_incr4();
      row_t rows[$];
      exp_t got, e;
      rows.push_back(mk(3'b110, 3'b000, NSQ, INC4, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b110, 3'b000, SEQ, INC4, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b110, 3'b000, SEQ, INC4, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b110, 3'b000, SEQ, INC4, 1'b1, 1'b0, 3'b100, 4'd1, 1'b0));
      rows.push_back(mk(3'b110, 3'b000, IDL, SGL,  1'b1, 1'b0, 3'b010, 4'd2, 1'b0));
      foreach (rows[i]) begin
         apply(rows[i]);
         got = {HGRANT, HMASTER, HMASTLOCK};
         e   = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL burst_incr4[%0d]: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                     i, got.g, got.m, got.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_burst_wait_busy();
      row_t rows[$];
      exp_t got, e;
      rows.push_back(mk(3'b111, 3'b000, NSQ, INC8, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, SEQ, INC8, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, BSY, INC8, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      for (int i = 0; i < 3; i++)
         rows.push_back(mk(3'b111, 3'b000, SEQ, INC8, 1'b0, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, SEQ, INC8, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, BSY, INC8, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      for (int i = 0; i < 4; i++)
         rows.push_back(mk(3'b111, 3'b000, SEQ, INC8, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, SEQ, INC8, 1'b1, 1'b0, 3'b100, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, IDL, SGL,  1'b1, 1'b0, 3'b001, 4'd2, 1'b0));
      foreach (rows[i]) begin
         apply(rows[i]);
         got = {HGRANT, HMASTER, HMASTLOCK};
         e   = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL burst_wait_busy[%0d]: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                     i, got.g, got.m, got.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_lock();
      row_t rows[$];
      exp_t got, e;
      rows.push_back(mk(3'b100, 3'b000, NSQ, SGL, 1'b1, 1'b0, 3'b100, 4'd0, 1'b0));
      rows.push_back(mk(3'b111, 3'b100, NSQ, SGL, 1'b1, 1'b0, 3'b100, 4'd2, 1'b1));
      rows.push_back(mk(3'b111, 3'b100, NSQ, SGL, 1'b1, 1'b0, 3'b100, 4'd2, 1'b1));
      rows.push_back(mk(3'b111, 3'b100, NSQ, SGL, 1'b1, 1'b1, 3'b100, 4'd2, 1'b1));
      rows.push_back(mk(3'b111, 3'b100, NSQ, SGL, 1'b1, 1'b0, 3'b100, 4'd2, 1'b1));
      rows.push_back(mk(3'b111, 3'b100, NSQ, SGL, 1'b1, 1'b0, 3'b100, 4'd2, 1'b1));
      rows.push_back(mk(3'b111, 3'b000, NSQ, SGL, 1'b1, 1'b0, 3'b100, 4'd2, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, NSQ, SGL, 1'b1, 1'b0, 3'b001, 4'd2, 1'b0));
      foreach (rows[i]) begin
         apply(rows[i]);
         got = {HGRANT, HMASTER, HMASTLOCK};
         e   = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL lock[%0d]: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                     i, got.g, got.m, got.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_lock_with_burst();
      row_t rows[$];
      exp_t got, e;
      rows.push_back(mk(3'b011, 3'b001, NSQ, INC4, 1'b1, 1'b0, 3'b001, 4'd0, 1'b1));
      for (int i = 0; i < 3; i++)
         rows.push_back(mk(3'b011, 3'b001, SEQ, INC4, 1'b1, 1'b0, 3'b001, 4'd0, 1'b1));
      rows.push_back(mk(3'b011, 3'b000, IDL, SGL, 1'b1, 1'b0, 3'b001, 4'd0, 1'b0));
      rows.push_back(mk(3'b011, 3'b000, IDL, SGL, 1'b1, 1'b0, 3'b010, 4'd0, 1'b0));
      foreach (rows[i]) begin
         apply(rows[i]);
         got = {HGRANT, HMASTER, HMASTLOCK};
         e   = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL lock_with_burst[%0d]: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                     i, got.g, got.m, got.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_error_abort();
      row_t rows[$];
      exp_t got, e;
      rows.push_back(mk(3'b101, 3'b000, NSQ, WR16, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      for (int i = 0; i < 4; i++)
         rows.push_back(mk(3'b101, 3'b000, SEQ, WR16, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b101, 3'b000, SEQ, WR16, 1'b1, 1'b1, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b101, 3'b000, IDL, SGL,  1'b1, 1'b0, 3'b100, 4'd1, 1'b0));
      foreach (rows[i]) begin
         apply(rows[i]);
         got = {HGRANT, HMASTER, HMASTLOCK};
         e   = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL error_abort[%0d]: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                     i, got.g, got.m, got.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_incr_and_early_term();
      row_t rows[$];
      exp_t got, e;
      rows.push_back(mk(3'b111, 3'b000, NSQ, INC,  1'b1, 1'b0, 3'b001, 4'd2, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, SEQ, INC,  1'b1, 1'b0, 3'b010, 4'd0, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, NSQ, INC4, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, SEQ, INC4, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, NSQ, INC4, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, SEQ, INC4, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, SEQ, INC4, 1'b1, 1'b0, 3'b010, 4'd1, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, SEQ, INC4, 1'b1, 1'b0, 3'b100, 4'd1, 1'b0));
      foreach (rows[i]) begin
         apply(rows[i]);
         got = {HGRANT, HMASTER, HMASTLOCK};
         e   = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL incr_early_term[%0d]: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                     i, got.g, got.m, got.l, e.g, e.m, e.l);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      row_t rows[$];
      exp_t got, e;
      rows.push_back(mk(3'b111, 3'b000, NSQ, INC16, 1'b1, 1'b0, 3'b100, 4'd2, 1'b0));
      rows.push_back(mk(3'b111, 3'b000, SEQ, INC16, 1'b1, 1'b0, 3'b100, 4'd2, 1'b0));
      foreach (rows[i]) begin
         apply(rows[i]);
         got = {HGRANT, HMASTER, HMASTLOCK};
         e   = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset_mid_burst[%0d]: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                     i, got.g, got.m, got.l, e.g, e.m, e.l);
         end
      end
      // Asynchronous reset between clock edges
      #2;
      HRESETn = 1'b0;
      exp_q.push_back({3'b001, 4'd0, 1'b0});
      #1;
      got = {HGRANT, HMASTER, HMASTLOCK};
      e   = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL reset_async: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                  got.g, got.m, got.l, e.g, e.m, e.l);
      end
      @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      rows.delete();
      rows.push_back(mk(3'b111, 3'b000, SEQ, INC16, 1'b1, 1'b0, 3'b010, 4'd0, 1'b0));
      rows.push_back(mk(3'b000, 3'b000, IDL, SGL,   1'b1, 1'b0, 3'b001, 4'd1, 1'b0));
      foreach (rows[i]) begin
         apply(rows[i]);
         got = {HGRANT, HMASTER, HMASTLOCK};
         e   = exp_q.pop_front();
         n_checks++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL post_reset[%0d]: got g=%b m=%0d l=%b, exp g=%b m=%0d l=%b",
                     i, got.g, got.m, got.l, e.g, e.m, e.l);
         end
      end
   endtask

   initial begin
      HRESETn = 1'b0;
      HBUSREQ = 3'b000;
      HLOCK   = 3'b000;
      HTRANS  = IDL;
      HBURST  = SGL;
      HREADY  = 1'b1;
      HRESP   = 2'd0;
      test_reset();
      test_round_robin();
      test_default_grant();
      test_burst_incr4();
      test_burst_wait_busy();
      test_lock();
      test_lock_with_burst();
      test_error_abort();
      test_incr_and_early_term();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
